// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter that shares a single synchronous FIFO write port
// among NUM_REQ producers. One producer owns the port at a time for a burst of
// up to BURST_MAX beats. A full FIFO stalls the burst without ending it. When
// the burst ends, the next owner is chosen in the same cycle, so back-to-back
// bursts have no idle bubble.
//
// Parameters
//   NUM_REQ    number of requesters (>= 2)
//   DATA_W     data width, equal to the FIFO data width
//   BURST_MAX  beats per grant before forced re-arbitration (>= 1)
//
// Ports
//   clk           in   rising-edge clock
//   reset_i       in   asynchronous, active-low reset
//   req_i         in   per-requester write request (level, held until granted)
//   data_i        in   packed producer data, slice k belongs to requester k
//   gnt_o         out  one-hot beat accept (combinational)
//   fifo_full_i   in   FIFO full flag
//   fifo_wr_en_o  out  FIFO write enable
//   fifo_data_o   out  FIFO write data
//   owner_o       out  current burst owner (meaningful while busy_o is high)
//   busy_o        out  a burst is in progress
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 3,
  parameter int BURST_MAX = 4
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*DATA_W-1:0]  data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  input  logic                       fifo_full_i,
  output logic                       fifo_wr_en_o,
  output logic [DATA_W-1:0]          fifo_data_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       busy_o
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_last;
  logic [CW-1:0] r_beat_cnt;

  logic              w_busy;
  logic              w_beat;
  logic              w_end;
  logic              w_found;
  logic [OW-1:0]     w_win;
  logic [OW-1:0]     w_base;
  logic [DATA_W-1:0] w_slice [NUM_REQ];

  assign w_busy = (r_state == S_BUSY);

  // A beat needs the owner still requesting and room in the FIFO. A full FIFO
  // only stalls; it never counts as the end of a burst.
  assign w_beat = w_busy & req_i[r_owner] & ~fifo_full_i;
  assign w_end  = w_busy & ((w_beat & (r_beat_cnt == CW'(BURST_MAX - 1)))
                            | ~req_i[r_owner]);

  // Search starts after the last owner when idle and after the current owner
  // when a burst ends. The current owner is searched last, so a sole
  // requester wins again.
  assign w_base = w_busy ? r_owner : r_last;

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment; otherwise a path that skips the assignment infers a latch.
    logic [OW-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    // Walk from the farthest candidate to the nearest so the nearest
    // requesting index is the one left in w_win.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = OW'((int'(w_base) + k) % NUM_REQ);
      if (req_i[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_slice[k] = data_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    gnt_o = '0;
    if (w_beat) begin
      gnt_o[r_owner] = 1'b1;
    end
  end

  assign fifo_wr_en_o = |gnt_o;
  assign fifo_data_o  = w_busy ? w_slice[r_owner] : '0;
  assign owner_o      = r_owner;
  assign busy_o       = w_busy;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      // Requester NUM_REQ-1 is marked as the last owner, so requester 0 has
      // top priority after reset. Any burst in flight is abandoned.
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_last     <= OW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples values from before the edge, whatever order the
      // statements appear in.
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_BUSY;
            r_owner    <= w_win;
            r_beat_cnt <= '0;
          end
        end
        default: begin
          if (w_end) begin
            r_last     <= r_owner;
            r_beat_cnt <= '0;
            if (w_found) begin
              r_owner <= w_win;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Bench for fifo_wr_arbiter with NUM_REQ=4, DATA_W=3, BURST_MAX=4, driving a
// behavioural model of an 8-deep synchronous FIFO. Expected beats (requester,
// data) are queued as stimulus is applied and compared as the arbiter writes.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 time
// units later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 3;
  localparam int BURST_MAX  = 4;
  localparam int FIFO_DEPTH = 8;

  typedef struct {
    int               id;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_full;
  logic                      wr_en;
  logic [DATA_W-1:0]         wdata;
  logic [1:0]                owner;
  logic                      busy;

  logic force_full;
  logic drain;
  logic cap_wr;
  logic cap_rd;
  int   fifo_cnt;

  int    checks;
  int    errors;
  int    wr_count [NUM_REQ];
  beat_t exp_q [$];

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk          (clk),
    .reset_i      (rst_n),
    .req_i        (req),
    .data_i       (data),
    .gnt_o        (gnt),
    .fifo_full_i  (fifo_full),
    .fifo_wr_en_o (wr_en),
    .fifo_data_o  (wdata),
    .owner_o      (owner),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO occupancy model, sharing the arbiter reset.
  assign fifo_full = force_full | (fifo_cnt >= FIFO_DEPTH);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_cnt <= 0;
    else        fifo_cnt <= fifo_cnt + (cap_wr ? 1 : 0) - (cap_rd ? 1 : 0);
  end

  task automatic push(input int id, input logic [DATA_W-1:0] d);
    beat_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    #2;
  endtask

  // Invariants every cycle, scoreboard compare on writes, then advance.
  task automatic commit();
    beat_t e;
    checks++;
    if (!$onehot0(gnt)) begin
      errors++;
      $display("FAIL gnt_onehot: gnt_o=%b, required at most one bit set", gnt);
    end
    checks++;
    if (wr_en !== (|gnt)) begin
      errors++;
      $display("FAIL wr_en_eq_or_gnt: wr_en=%b gnt_o=%b", wr_en, gnt);
    end
    checks++;
    if (wr_en === 1'b1 && fifo_full === 1'b1) begin
      errors++;
      $display("FAIL write_when_full: wr_en=%b full=%b, required wr_en=0", wr_en, fifo_full);
    end
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: gnt_o=%b data=%0d, required no write", gnt, wdata);
      end else begin
        e = exp_q.pop_front();
        if (gnt !== 4'(1 << e.id) || wdata !== e.data) begin
          errors++;
          $display("FAIL scoreboard_beat: gnt_o=%b data=%0d, required gnt_o=%b data=%0d",
                   gnt, wdata, 4'(1 << e.id), e.data);
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gnt[k] === 1'b1) wr_count[k]++;
      end
    end
    cap_wr = (wr_en === 1'b1);
    cap_rd = drain && (fifo_cnt > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n      = 1'b0;
    req        = '0;
    force_full = 1'b0;
    drain      = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NUM_REQ; k++) wr_count[k] = 0;
    settle(); commit();
    settle(); commit();
    rst_n = 1'b1;
  endtask

  task automatic check_cycle(input string name, input logic [3:0] exp_gnt,
                             input logic exp_busy, input logic [1:0] exp_owner);
    checks++;
    if (gnt !== exp_gnt || busy !== exp_busy || (exp_busy && owner !== exp_owner)) begin
      errors++;
      $display("FAIL %s: gnt_o=%b busy=%b owner=%0d, required gnt_o=%b busy=%b owner=%0d",
               name, gnt, busy, owner, exp_gnt, exp_busy, exp_owner);
    end
  endtask

  // 1: outputs held at zero in reset; requester 0 wins first after release.
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (gnt !== 4'b0 || wr_en !== 1'b0 || busy !== 1'b0 || owner !== 2'd0 || wdata !== 3'd0) begin
        errors++;
        $display("FAIL reset_outputs: gnt_o=%b wr_en=%b busy=%b owner=%0d data=%0d, required all 0",
                 gnt, wr_en, busy, owner, wdata);
      end
      commit();
    end
    rst_n = 1'b1;
    settle();
    check_cycle("reset_release_idle", 4'b0000, 1'b0, 2'd0);
    checks++;
    if (wdata !== 3'd0) begin
      errors++;
      $display("FAIL idle_data: data=%0d, required 0", wdata);
    end
    commit();
    push(0, 3'd1);
    settle();
    check_cycle("reset_first_grant_req0", 4'b0001, 1'b1, 2'd0);
    commit();
    req = '0;
    settle(); commit();
    settle(); commit();
  endtask

  // 2: sole requester, back-to-back bursts without a bubble until FIFO full.
  task automatic test_back_to_back();
    reset_dut();
    req  = 4'b0010;
    data = {3'd0, 3'd0, 3'd5, 3'd0};
    settle();
    check_cycle("b2b_idle", 4'b0000, 1'b0, 2'd0);
    commit();
    for (int i = 0; i < FIFO_DEPTH; i++) push(1, 3'd5);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      settle();
      check_cycle($sformatf("b2b_beat%0d", i), 4'b0010, 1'b1, 2'd1);
      commit();
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      check_cycle($sformatf("b2b_full%0d", i), 4'b0000, 1'b1, 2'd1);
      commit();
    end
    checks++;
    if (wr_count[1] != FIFO_DEPTH) begin
      errors++;
      $display("FAIL b2b_word_count: writes=%0d, required %0d", wr_count[1], FIFO_DEPTH);
    end
    req = '0;
    settle(); commit();
  endtask

  // 3: all requesters active, FIFO drained every cycle.
  task automatic test_round_robin();
    int order [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    reset_dut();
    req   = 4'b1111;
    data  = {3'd3, 3'd2, 3'd1, 3'd0};
    drain = 1'b1;
    for (int i = 0; i < 17; i++) push(order[i], 3'(order[i]));
    settle();
    check_cycle("rr_idle", 4'b0000, 1'b0, 2'd0);
    commit();
    for (int i = 0; i < 17; i++) begin
      settle();
      check_cycle($sformatf("rr_beat%0d", i), 4'(1 << order[i]), 1'b1, 2'(order[i]));
      commit();
    end
    req = '0;
    settle(); commit();
    settle(); commit();
    drain = 1'b0;
  endtask

  // 4: full stall in the middle of a burst holds owner and beat count.
  task automatic test_full_stall();
    reset_dut();
    req   = 4'b0011;
    data  = {3'd0, 3'd0, 3'd2, 3'd6};
    drain = 1'b1;
    for (int i = 0; i < 4; i++) push(0, 3'd6);
    push(1, 3'd2);
    settle(); commit();
    for (int i = 0; i < 2; i++) begin
      settle();
      check_cycle($sformatf("stall_pre%0d", i), 4'b0001, 1'b1, 2'd0);
      commit();
    end
    force_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_cycle($sformatf("stall_hold%0d", i), 4'b0000, 1'b1, 2'd0);
      commit();
    end
    force_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_cycle($sformatf("stall_post%0d", i), 4'b0001, 1'b1, 2'd0);
      commit();
    end
    settle();
    check_cycle("stall_next_req1", 4'b0010, 1'b1, 2'd1);
    commit();
    req = '0;
    settle(); commit();
    drain = 1'b0;
  endtask

  // 5: owner drops its request after one beat; pending requester 2 follows.
  task automatic test_req_drop();
    reset_dut();
    req   = 4'b0101;
    data  = {3'd0, 3'd7, 3'd0, 3'd3};
    drain = 1'b1;
    push(0, 3'd3);
    push(2, 3'd7);
    push(2, 3'd7);
    settle(); commit();
    settle();
    check_cycle("drop_beat_req0", 4'b0001, 1'b1, 2'd0);
    commit();
    req = 4'b0100;
    settle();
    check_cycle("drop_end_cycle", 4'b0000, 1'b1, 2'd0);
    commit();
    for (int i = 0; i < 2; i++) begin
      settle();
      check_cycle($sformatf("drop_req2_%0d", i), 4'b0100, 1'b1, 2'd2);
      commit();
    end
    req = '0;
    settle(); commit();
    checks++;
    if (wr_count[0] != 1) begin
      errors++;
      $display("FAIL drop_req0_words: writes=%0d, required 1", wr_count[0]);
    end
    drain = 1'b0;
  endtask

  // 6: asynchronous reset during beat 2 of requester 3.
  task automatic test_reset_mid_burst();
    reset_dut();
    req   = 4'b1000;
    data  = {3'd6, 3'd0, 3'd0, 3'd1};
    drain = 1'b1;
    push(3, 3'd6);
    settle(); commit();
    settle();
    check_cycle("midrst_beat1", 4'b1000, 1'b1, 2'd3);
    commit();
    settle();
    check_cycle("midrst_beat2_presented", 4'b1000, 1'b1, 2'd3);
    #2;
    rst_n = 1'b0;
    req   = 4'b1001;
    #1;
    checks++;
    if (gnt !== 4'b0 || wr_en !== 1'b0 || busy !== 1'b0 || owner !== 2'd0 || wdata !== 3'd0) begin
      errors++;
      $display("FAIL midrst_immediate: gnt_o=%b wr_en=%b busy=%b owner=%0d data=%0d, required all 0",
               gnt, wr_en, busy, owner, wdata);
    end
    cap_wr = 1'b0;
    cap_rd = 1'b0;
    @(posedge clk);
    #1;
    settle();
    check_cycle("midrst_held", 4'b0000, 1'b0, 2'd0);
    commit();
    rst_n = 1'b1;
    settle();
    check_cycle("midrst_release_idle", 4'b0000, 1'b0, 2'd0);
    commit();
    push(0, 3'd1);
    settle();
    check_cycle("midrst_req0_first", 4'b0001, 1'b1, 2'd0);
    commit();
    req = '0;
    settle(); commit();
    settle(); commit();
    checks++;
    if (wr_count[3] != 1) begin
      errors++;
      $display("FAIL midrst_req3_words: writes=%0d, required 1", wr_count[3]);
    end
    drain = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req        = '0;
    data       = '0;
    force_full = 1'b0;
    drain      = 1'b0;
    cap_wr     = 1'b0;
    cap_rd     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) wr_count[k] = 0;
    @(posedge clk);
    #1;

    test_reset();
    test_back_to_back();
    test_round_robin();
    test_full_stall();
    test_req_drop();
    test_reset_mid_burst();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: pending=%0d, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
